// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register for the 5-stage core.
//   Holds the PC, drives the instruction-memory address, and latches the
//   fetched word together with PC+4 for decode. A taken branch from EX
//   redirects the PC and flushes IF/ID to a bubble. A freeze from hazard
//   detection holds both the PC and IF/ID. Saturating counters record
//   stalled cycles and branch flushes for performance debug.
//
// Ports
//   clk              core clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   freeze           stall request from hazard detection
//   branch_taken     branch resolved taken in EX this cycle
//   branch_addr      branch target, low two bits ignored
//   imem_addr        instruction-memory address, equal to the PC register
//   imem_rdata       instruction word, combinational read of imem_addr
//   pc_out           IF/ID: PC+4 of the latched instruction
//   instruction_out  IF/ID: latched instruction (0 for a bubble)
//   valid_out        IF/ID: 1 = real instruction, 0 = bubble
//   stall_count      saturating count of frozen cycles
//   flush_count      saturating count of branch flushes
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc_out,
  output logic [31:0]      instruction_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Target is always word aligned; the low bits of branch_addr are dropped.
  logic [1:0] branch_addr_unused;
  assign branch_addr_unused = branch_addr[1:0];

  assign imem_addr = pc;
  // Wraps modulo 2^32 by construction.
  assign pc_plus4  = pc + 32'd4;

  // Priority: rst > branch_taken > freeze > normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= RESET_PC;
      pc_out          <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
      stall_count     <= '0;
      flush_count     <= '0;
    end else if (branch_taken) begin
      // Freeze is ignored here so a redirect is never lost behind a stall.
      pc              <= {branch_addr[31:2], 2'b00};
      pc_out          <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
      if (flush_count != CNT_MAX) begin
        flush_count <= flush_count + 1'b1;
      end
    end else if (freeze) begin
      if (stall_count != CNT_MAX) begin
        stall_count <= stall_count + 1'b1;
      end
    end else begin
      pc              <= pc_plus4;
      pc_out          <= pc_plus4;
      instruction_out <= imem_rdata;
      valid_out       <= 1'b1;
    end
  end

endmodule
